// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, output width derivation and FSM states for conv
package conv_pkg;

   localparam int DEF_KERNEL_SIZE       = 3;
   localparam int DEF_INPUT_TILE_SIZE   = 3;
   localparam int DEF_INPUT_DATA_WIDTH  = 8;
   localparam int DEF_KERNEL_DATA_WIDTH = 8;
   localparam int DEF_CHANNELS          = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      COMP = 2'd2,
      DONE = 2'd3
   } conv_state_e;

   // 8 bits of headroom keep C*K^2 <= 256 full-scale products from overflowing
   function automatic int out_width(input int di, input int dk);
      return di + dk + 8;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - signed multiply with sign-extended wrapping accumulate
module conv_mac
   import conv_pkg::*;
#(
   parameter int DI = DEF_INPUT_DATA_WIDTH,
   parameter int DK = DEF_KERNEL_DATA_WIDTH,
   parameter int DO = out_width(DEF_INPUT_DATA_WIDTH, DEF_KERNEL_DATA_WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr,
   input  logic signed [DI-1:0] a,
   input  logic signed [DK-1:0] b,
   output logic signed [DO-1:0] sum
);

   logic signed [DO-1:0]    acc;
   logic signed [DI+DK-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + {{(DO-DI-DK){prod[DI+DK-1]}}, prod};

   // sum already carries the current term, so clearing on the last term loses nothing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr ? '0 : sum;
      end
   end

endmodule

// File: rtl/conv.sv
// rtl/conv.sv - multi-channel valid 2D convolution over one tile with one MAC
module conv
   import conv_pkg::*;
#(
   parameter int KERNEL_SIZE       = DEF_KERNEL_SIZE,
   parameter int INPUT_TILE_SIZE   = DEF_INPUT_TILE_SIZE,
   parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
   parameter int KERNEL_DATA_WIDTH = DEF_KERNEL_DATA_WIDTH,
   parameter int CHANNELS          = DEF_CHANNELS,
   localparam int OUTPUT_BIT_WIDTH = out_width(INPUT_DATA_WIDTH, KERNEL_DATA_WIDTH),
   localparam int OUTPUT_TILE_SIZE = INPUT_TILE_SIZE - KERNEL_SIZE + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH*CHANNELS-1:0]         kernel,
   input  logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH*CHANNELS-1:0] inpData,
   output logic [OUTPUT_TILE_SIZE*OUTPUT_TILE_SIZE*OUTPUT_BIT_WIDTH-1:0]       outData,
   output logic finalCompute
);

   localparam int DI = INPUT_DATA_WIDTH;
   localparam int DK = KERNEL_DATA_WIDTH;
   localparam int DO = OUTPUT_BIT_WIDTH;
   localparam int M  = OUTPUT_TILE_SIZE;
   localparam int KW = KERNEL_SIZE*KERNEL_SIZE*DK*CHANNELS;
   localparam int IW = INPUT_TILE_SIZE*INPUT_TILE_SIZE*DI*CHANNELS;

   localparam logic [15:0] KM1 = 16'(KERNEL_SIZE - 1);
   localparam logic [15:0] CM1 = 16'(CHANNELS - 1);
   localparam logic [15:0] MM1 = 16'(M - 1);
   localparam logic [31:0] K32 = 32'(KERNEL_SIZE);
   localparam logic [31:0] N32 = 32'(INPUT_TILE_SIZE);
   localparam logic [31:0] M32 = 32'(M);

   conv_state_e state;
   logic [KW-1:0] kernel_q;
   logic [IW-1:0] inp_q;
   logic [15:0]   j, i, ch, ocol, orow;
   logic [31:0]   in_idx, k_idx, pix;
   logic signed [DI-1:0] a;
   logic signed [DK-1:0] b;
   logic signed [DO-1:0] sum;
   logic          mac_en, last_term, last_pix;
   logic [DO-1:0] out_q [M*M];

   always_comb begin
      in_idx    = (32'(ch)*N32 + 32'(orow) + 32'(i))*N32 + 32'(ocol) + 32'(j);
      k_idx     = (32'(ch)*K32 + 32'(i))*K32 + 32'(j);
      pix       = 32'(orow)*M32 + 32'(ocol);
      a         = DI'(inp_q >> (in_idx*DI));
      b         = DK'(kernel_q >> (k_idx*DK));
      mac_en    = (state == COMP);
      last_term = (j == KM1) && (i == KM1) && (ch == CM1);
      last_pix  = last_term && (ocol == MM1) && (orow == MM1);
   end

   conv_mac #(.DI(DI), .DK(DK), .DO(DO)) u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (mac_en),
      .clr   (last_term),
      .a     (a),
      .b     (b),
      .sum   (sum)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         kernel_q     <= '0;
         inp_q        <= '0;
         j            <= '0;
         i            <= '0;
         ch           <= '0;
         ocol         <= '0;
         orow         <= '0;
         finalCompute <= 1'b0;
         for (int p = 0; p < M*M; p++) out_q[p] <= '0;
      end else begin
         case (state)
            // IDLE only persists through reset, so the first live edge is the load edge
            IDLE, LOAD: begin
               kernel_q <= kernel;
               inp_q    <= inpData;
               state    <= COMP;
            end
            COMP: begin
               if (last_term) begin
                  for (int p = 0; p < M*M; p++) begin
                     if (32'(p) == pix) out_q[p] <= sum;
                  end
               end
               if (last_pix) begin
                  state        <= DONE;
                  finalCompute <= 1'b1;
               end
               if (j != KM1) begin
                  j <= j + 16'd1;
               end else begin
                  j <= '0;
                  if (i != KM1) begin
                     i <= i + 16'd1;
                  end else begin
                     i <= '0;
                     if (ch != CM1) begin
                        ch <= ch + 16'd1;
                     end else begin
                        ch <= '0;
                        if (ocol != MM1) begin
                           ocol <= ocol + 16'd1;
                        end else begin
                           ocol <= '0;
                           if (orow != MM1) orow <= orow + 16'd1;
                           else             orow <= '0;
                        end
                     end
                  end
               end
            end
            default: state <= DONE;
         endcase
      end
   end

   for (genvar g = 0; g < M*M; g++) begin : g_out
      assign outData[g*DO +: DO] = out_q[g];
   end

endmodule

// File: tb/tb_conv.sv
// tb/tb_conv.sv - directed vector bench for conv
module tb_conv;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         reset4 = 1'b0;
   logic [215:0] kernel = '0;
   logic [215:0] inpData = '0;
   logic [23:0]  outData;
   logic         finalCompute;
   logic [71:0]  kernel4 = '0;
   logic [127:0] inpData4 = '0;
   logic [95:0]  outData4;
   logic         finalCompute4;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string      name;
      bit         ramp;
      bit         extreme;
      logic [7:0] r, g, b;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   conv dut (
      .clk          (clk),
      .reset        (reset),
      .kernel       (kernel),
      .inpData      (inpData),
      .outData      (outData),
      .finalCompute (finalCompute)
   );

   conv #(.INPUT_TILE_SIZE(4), .CHANNELS(1)) dut4 (
      .clk          (clk),
      .reset        (reset4),
      .kernel       (kernel4),
      .inpData      (inpData4),
      .outData      (outData4),
      .finalCompute (finalCompute4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [71:0] blur_kernel();
      logic [71:0] k;
      logic [7:0]  w[9];
      w = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
      for (int e = 0; e < 9; e++) k[e*8 +: 8] = w[e];
      return k;
   endfunction

   function automatic logic [215:0] build_input(input vec_t v);
      logic [215:0] d;
      logic [7:0]   cv;
      for (int ch = 0; ch < 3; ch++) begin
         cv = (ch == 0) ? v.r : (ch == 1) ? v.g : v.b;
         for (int e = 0; e < 9; e++) d[(ch*9+e)*8 +: 8] = v.ramp ? 8'(ch*9+e) : cv;
      end
      return d;
   endfunction

   function automatic logic [215:0] build_kernel(input bit extreme);
      logic [215:0] k;
      for (int ch = 0; ch < 3; ch++) k[ch*72 +: 72] = extreme ? {9{8'h80}} : blur_kernel();
      return k;
   endfunction

   task automatic run_tile(input string name, input logic [215:0] inp, input logic [215:0] ker,
                           input logic [23:0] exp, input bit disturb);
      int edges;
      reset = 1'b0;
      inpData = inp;
      kernel = ker;
      repeat (2) @(negedge clk);
      chk({name, "_rst_out"}, 64'(outData), 64'h0);
      chk({name, "_rst_fc"}, 64'(finalCompute), 64'h0);
      reset = 1'b1;
      edges = 0;
      while (!finalCompute && edges < 100) begin
         @(posedge clk);
         edges++;
         #1;
         if (disturb && edges == 1) begin
            inpData = ~inp;
            kernel  = ~ker;
         end
      end
      chk({name, "_latency"}, 64'(edges), 64'd28);
      chk({name, "_out"}, 64'(outData), 64'(exp));
      repeat (3) @(negedge clk);
      chk({name, "_hold"}, 64'({finalCompute, outData}), 64'({1'b1, exp}));
   endtask

   initial begin
      int edges;
      vecs[0] = '{"ones",    1'b0, 1'b0, 8'd1,   8'd1,   8'd1,   24'h000030};
      vecs[1] = '{"hundred", 1'b0, 1'b0, 8'd100, 8'd100, 8'd100, 24'h0012C0};
      vecs[2] = '{"neg1",    1'b0, 1'b0, 8'hFF,  8'hFF,  8'hFF,  24'hFFFFD0};
      vecs[3] = '{"extreme", 1'b0, 1'b1, 8'h80,  8'h80,  8'h80,  24'h06C000};
      vecs[4] = '{"red_only",1'b0, 1'b0, 8'd5,   8'd0,   8'd0,   24'h000050};
      vecs[5] = '{"ramp",    1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   24'h000270};

      for (int v = 0; v < 6; v++)
         run_tile(vecs[v].name, build_input(vecs[v]), build_kernel(vecs[v].extreme), vecs[v].exp, 1'b0);

      run_tile("red_disturb", build_input(vecs[4]), build_kernel(1'b0), 24'h000050, 1'b1);

      // abort part-way through COMP, then rerun the same tile cleanly
      reset = 1'b0;
      inpData = build_input(vecs[0]);
      kernel = build_kernel(1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_out", 64'(outData), 64'h0);
      chk("midrst_fc", 64'(finalCompute), 64'h0);
      run_tile("rerun", build_input(vecs[0]), build_kernel(1'b0), 24'h000030, 1'b0);

      kernel4 = blur_kernel();
      inpData4 = {16{8'd1}};
      repeat (2) @(negedge clk);
      chk("n4_rst", 64'({finalCompute4, outData4[63:0]}), 64'h0);
      reset4 = 1'b1;
      edges = 0;
      while (!finalCompute4 && edges < 100) begin
         @(posedge clk);
         edges++;
         #1;
      end
      chk("n4_latency", 64'(edges), 64'd37);
      for (int p = 0; p < 4; p++) chk($sformatf("n4_out%0d", p), 64'(outData4[p*24 +: 24]), 64'd16);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/conv.md
# conv

Multi-channel 2D "valid" convolution engine for one input tile. It captures a packed signed input tile and kernel, then accumulates all channels into an (INPUT_TILE_SIZE−KERNEL_SIZE+1)² signed output tile using a single sequential multiply-accumulate datapath. It raises `finalCompute` when done. It sits between the patch-fetch logic and the output writer in the image-filter pipeline. Each new tile is started by a reset pulse.

## Interface
Parameters:
- `KERNEL_SIZE`, 3: kernel side K.
- `INPUT_TILE_SIZE`, 3: input tile side N; must satisfy N ≥ K.
- `INPUT_DATA_WIDTH`, 8: signed input element width DI.
- `KERNEL_DATA_WIDTH`, 8: signed kernel element width DK.
- `CHANNELS`, 3: channel count C.
- `OUTPUT_BIT_WIDTH` (localparam), DI+DK+8: signed output element width DO.
- `OUTPUT_TILE_SIZE` (localparam), N−K+1: output side M.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `kernel`, in, K·K·DK·C: signed kernel. Element (ch,r,c) is at bits [((ch·K+r)·K+c)·DK +: DK].
- `inpData`, in, N·N·DI·C: signed input tile. Element (ch,r,c) is at bits [((ch·N+r)·N+c)·DI +: DI].
- `outData`, out, M·M·DO: signed output tile. Element (r,c) is at bits [(r·M+c)·DO +: DO]. Registered.
- `finalCompute`, out, 1: high when `outData` is complete. Registered.

## Operation
Each output element is the cross-correlation sum (no kernel flip):
- out(r,c) = Σ over ch, i, j of in(ch, r+i, c+j) · k(ch, i, j).

Arithmetic rules:
- Each product is a full signed product of DI+DK bits, sign-extended to DO.
- Accumulation is in DO bits and wraps modulo 2^DO.
- The 8-bit headroom guarantees no overflow for C·K² ≤ 256.

FSM states:
- IDLE: held while `reset` is low. `outData` = 0, `finalCompute` = 0, accumulator and counters = 0.
- LOAD: the first rising edge after `reset` goes high registers `inpData` and `kernel` into internal copies, then moves to COMP.
  - Input changes after this edge are ignored for the rest of the tile.
- COMP: performs one MAC per cycle.
  - Loop order, innermost first: j, i, ch, then output column, then output row.
  - When a pixel's last term is added, the sum is written into its `outData` slot and the accumulator is cleared for the next pixel.
  - After the last term of the last pixel, moves to DONE.
- DONE: `finalCompute` = 1. `outData` and `finalCompute` hold until reset; there is no automatic restart.

Reset behaviour:
- Asserting `reset` in any state, including mid-COMP, immediately clears all outputs and state. A partial result is never exposed.

## Timing
- Total latency L = 1 + M²·C·K² rising edges after `reset` deasserts. The default configuration gives L = 28.
- `finalCompute` rises on edge L, in the same edge as the final `outData` slot write.
- Earlier `outData` slots are written progressively during COMP. The tile is valid only when `finalCompute` = 1.
- Handshake: the producer must drive `inpData` and `kernel` stable before the first rising edge after reset release. The consumer samples `outData` whenever `finalCompute` = 1.
- A reset pulse of at least one clock period between tiles is sufficient.

## Structure
- Shared package `conv_pkg`:
  - Default width constants.
  - The DO derivation function (DI+DK+8).
  - The FSM state enum (IDLE, LOAD, COMP, DONE).
- One sub-module `conv_mac`: a signed DI×DK multiply with DO-bit sign-extended accumulate, plus a clear input. The top level holds the FSM, the index counters, the element-select muxes and the output register file.

## Test plan
Defaults for all cases: N=K=3, C=3, kernel [1 2 1; 2 4 2; 1 2 1] on every channel.
- All inputs = 1 -> `outData` = 24'h000030 (48); `finalCompute` rises exactly 28 edges after reset release.
- All inputs = 100 -> `outData` = 24'h0012C0 (4800).
- All inputs = −1 -> `outData` = 24'hFFFFD0 (−48); checks signed handling.
- Extreme case: all inputs = −128, all kernel elements = −128 -> `outData` = 24'h06C000 (442368); checks width/no-overflow.
- Channel isolation: red channel = 5 in every element, green and blue = 0 -> 24'h000050 (80). Change `inpData` after the LOAD edge -> result is unchanged.
- Reset mid-COMP (at edge 10), then release with all inputs = 1 -> outputs read 0 and `finalCompute` = 0 during reset. The rerun yields 24'h000030 after 28 edges.
- Optional: N=4, K=3, C=1, all inputs = 1 -> four outputs each 16; `finalCompute` rises at edge 37.
